// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing defaults and geometry helpers for the VGA raster generator.
package vga_timing_pkg;

  localparam int   DEF_H_SYNC   = 96;
  localparam int   DEF_H_BP     = 48;
  localparam int   DEF_H_ACTIVE = 640;
  localparam int   DEF_H_FP     = 16;
  localparam int   DEF_V_SYNC   = 2;
  localparam int   DEF_V_BP     = 29;
  localparam int   DEF_V_ACTIVE = 480;
  localparam int   DEF_V_FP     = 10;
  localparam logic DEF_HS_POL   = 1'b0;
  localparam logic DEF_VS_POL   = 1'b0;

  function automatic int axis_total(input int sync, input int bp, input int active,
                                    input int fp);
    return sync + bp + active + fp;
  endfunction

  // True when every segment is non-empty and the last count fits in cw bits.
  function automatic bit axis_fits(input int sync, input int bp, input int active,
                                   input int fp, input int cw);
    longint last;
    last = longint'(axis_total(sync, bp, active, fp)) - 1;
    return (sync >= 1) && (bp >= 1) && (active >= 1) && (fp >= 1) &&
           (cw >= 1) && (cw < 32) && (last < (longint'(1) << cw));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: free-running position counter with sync/active region decode.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int CW     = 10
) (
  input  logic          clk_40ns,
  input  logic          rst,
  input  logic          step,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          in_sync,
  output logic          in_active,
  output logic [CW-1:0] pos
);

  localparam logic [CW-1:0] LAST      = CW'(axis_total(SYNC, BP, ACTIVE, FP) - 1);
  localparam logic [CW-1:0] SYNC_END  = CW'(SYNC);
  localparam logic [CW-1:0] ACT_START = CW'(SYNC + BP);
  localparam logic [CW-1:0] ACT_END   = CW'(SYNC + BP + ACTIVE);

  always_ff @(posedge clk_40ns or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (step) begin
      cnt <= wrap ? '0 : cnt + CW'(1);
    end
  end

  assign wrap      = (cnt == LAST);
  assign in_sync   = (cnt < SYNC_END);
  assign in_active = (cnt >= ACT_START) && (cnt < ACT_END);
  assign pos       = in_active ? (cnt - ACT_START) : '0;

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with registered, skew-free outputs.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter logic HS_POL   = DEF_HS_POL,
  parameter logic VS_POL   = DEF_VS_POL,
  parameter int   CW       = 10,
  parameter int   FCW      = 16
) (
  input  logic           clk_40ns,
  input  logic           rst,
  input  logic           ce,
  output logic           hsync,
  output logic           vsync,
  output logic           de,
  output logic [CW-1:0]  x,
  output logic [CW-1:0]  y,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_cnt
);

  if (!axis_fits(H_SYNC, H_BP, H_ACTIVE, H_FP, CW)) begin : g_bad_h_geometry
    $error("vga_timing_gen: horizontal timing must be >=1 per segment and H_TOTAL-1 must fit in CW bits");
  end
  if (!axis_fits(V_SYNC, V_BP, V_ACTIVE, V_FP, CW)) begin : g_bad_v_geometry
    $error("vga_timing_gen: vertical timing must be >=1 per segment and V_TOTAL-1 must fit in CW bits");
  end
  if (FCW < 1) begin : g_bad_fcw
    $error("vga_timing_gen: FCW must be at least 1");
  end

  // Stage p0: counter position currently being presented
  logic [CW-1:0] h_cnt_p0, v_cnt_p0, h_pos_p0, v_pos_p0;
  logic          h_wrap_p0, h_sync_p0, v_sync_p0, h_act_p0, v_act_p0;
  logic          v_wrap_unused;
  logic          at_line_p0, at_frame_p0;

  vga_axis_counter #(
    .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CW(CW)
  ) u_h_axis (
    .clk_40ns  (clk_40ns),
    .rst       (rst),
    .step      (ce),
    .cnt       (h_cnt_p0),
    .wrap      (h_wrap_p0),
    .in_sync   (h_sync_p0),
    .in_active (h_act_p0),
    .pos       (h_pos_p0)
  );

  vga_axis_counter #(
    .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CW(CW)
  ) u_v_axis (
    .clk_40ns  (clk_40ns),
    .rst       (rst),
    .step      (ce & h_wrap_p0),
    .cnt       (v_cnt_p0),
    .wrap      (v_wrap_unused),
    .in_sync   (v_sync_p0),
    .in_active (v_act_p0),
    .pos       (v_pos_p0)
  );

  assign at_line_p0  = (h_cnt_p0 == '0);
  assign at_frame_p0 = at_line_p0 && (v_cnt_p0 == '0);

  // Stage p1: registered outputs, all from the same p0 sample
  logic          hsync_p1, vsync_p1, de_p1, line_start_p1, frame_start_p1;
  logic [CW-1:0] x_p1, y_p1;

  always_ff @(posedge clk_40ns or posedge rst) begin
    if (rst) begin
      hsync_p1       <= ~HS_POL;
      vsync_p1       <= ~VS_POL;
      de_p1          <= 1'b0;
      x_p1           <= '0;
      y_p1           <= '0;
      line_start_p1  <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      // Strobes drop on the following clock whether or not ce is high.
      line_start_p1  <= ce && at_line_p0;
      frame_start_p1 <= ce && at_frame_p0;
      if (ce) begin
        hsync_p1 <= h_sync_p0 ? HS_POL : ~HS_POL;
        vsync_p1 <= v_sync_p0 ? VS_POL : ~VS_POL;
        de_p1    <= h_act_p0 && v_act_p0;
        x_p1     <= (h_act_p0 && v_act_p0) ? h_pos_p0 : '0;
        y_p1     <= (h_act_p0 && v_act_p0) ? v_pos_p0 : '0;
      end
    end
  end

  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign de          = de_p1;
  assign x           = x_p1;
  assign y           = y_p1;
  assign line_start  = line_start_p1;
  assign frame_start = frame_start_p1;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FCW-1:0] frame_cnt_p1;
  logic           frame_seen;

  // The first frame_start after reset opens a frame rather than completing one.
  always_ff @(posedge clk_40ns or posedge rst) begin
    if (rst) begin
      frame_cnt_p1 <= '0;
      frame_seen   <= 1'b0;
    end else if (ce && at_frame_p0) begin
      frame_seen <= 1'b1;
      if (frame_seen) begin
        frame_cnt_p1 <= frame_cnt_p1 + FCW'(1);
      end
    end
  end

  assign frame_cnt = frame_cnt_p1;
`else
  assign frame_cnt = '0;
`endif

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator and successor to the fixed 640x480 generator. It produces sync, data-enable and active-area pixel coordinates for any porch/sync/active geometry, with programmable sync polarity and a pixel-clock enable. All outputs are registered and mutually aligned, and it adds frame- and line-start strobes. It sits between the clock divider and the pixel renderers (ball, court, paddles), which consume `x`, `y` and `de` directly.

## Interface
- `H_SYNC`, 96, horizontal sync width in pixels
- `H_BP`, 48, horizontal back porch
- `H_ACTIVE`, 640, horizontal active pixels
- `H_FP`, 16, horizontal front porch
- `V_SYNC`, 2, vertical sync width in lines
- `V_BP`, 29, vertical back porch
- `V_ACTIVE`, 480, vertical active lines
- `V_FP`, 10, vertical front porch
- `HS_POL`, 0, hsync active level
- `VS_POL`, 0, vsync active level
- `CW`, 10, counter and coordinate width
- `FCW`, 16, frame counter width
- `clk_40ns` in 1: pixel clock
- `rst` in 1: asynchronous, active-high reset
- `ce` in 1: pixel advance enable; tie to 1 for full rate
- `hsync` out 1: horizontal sync, active at `HS_POL`
- `vsync` out 1: vertical sync, active at `VS_POL`
- `de` out 1: active-area data enable
- `x` out CW: active-area column, 0..H_ACTIVE-1; 0 outside the active area
- `y` out CW: active-area row, 0..V_ACTIVE-1; 0 outside the active area
- `line_start` out 1: one-clock strobe at h_cnt==0
- `frame_start` out 1: one-clock strobe at h_cnt==0 and v_cnt==0
- `frame_cnt` out FCW: completed-frame counter

## Operation
- Internal counters `h_cnt` and `v_cnt`. Totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP (800) and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP (521).
- Line order starting at count 0: sync, back porch, active, front porch. The same order applies vertically.
- On a clk edge with `ce`=1:
  - `h_cnt` increments and wraps from H_TOTAL-1 to 0.
  - At that wrap, `v_cnt` increments and wraps from V_TOTAL-1 to 0.
- When `ce`=0, counters and all level outputs hold.
- Level outputs are registered on `ce` edges from the pre-increment counter values:
  - `hsync`=HS_POL while h_cnt<H_SYNC.
  - `vsync`=VS_POL while v_cnt<V_SYNC.
  - `de`=1 while H_SYNC+H_BP ≤ h_cnt < H_SYNC+H_BP+H_ACTIVE, and likewise for v_cnt.
  - `x`=h_cnt-(H_SYNC+H_BP) and `y`=v_cnt-(V_SYNC+V_BP) when `de`; otherwise both are 0.
- Strobes:
  - `line_start` and `frame_start` are set on a `ce` edge whose pre-increment count matches their condition.
  - They clear on the next clk edge regardless of `ce`, so they are high for exactly one clk cycle.
- Sync and `de` derive from the same counter sample, so there is zero skew between them. This differs from the previous generator's mixed combinational/registered outputs.
- Reset state (asynchronous):
  - Counters at 0.
  - `hsync`=~HS_POL and `vsync`=~VS_POL.
  - `de`=0, `x`=0, `y`=0, both strobes 0.
  - `frame_cnt`=0.
- Reset asserted mid-frame aborts the frame immediately. After release, the first `ce` edge reports count (0,0): it asserts both syncs and both strobes.
- Elaboration check: H_TOTAL-1 and V_TOTAL-1 must fit in CW bits, and all timing parameters must be ≥1. Violation is an elaboration error.

## Timing
- Latency: outputs on the clk edge after a `ce` sample describe that counter position. This is one cycle of pipeline, identical for every output.
- With `ce`=1 constantly:
  - One line is H_TOTAL clocks; one frame is H_TOTAL·V_TOTAL clocks (416800 at defaults).
  - `hsync` is low for 96 clocks per line and `vsync` is low for 2 lines.
- With `ce` pulsed every N clocks: level outputs change only on `ce` edges, and strobes still last one clk.
- Wrap at (H_TOTAL-1, V_TOTAL-1): on the next `ce` edge, both counters return to 0 in the same edge.

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - `frame_cnt` increments on every edge that sets `frame_start`, wrapping 2^FCW-1 → 0.
  - The first `frame_start` after reset does not increment it, so `frame_cnt` counts completed frames.
- Undefined: `frame_cnt` is a constant 0 and no counter register is built. The port is retained so instantiations are unchanged.

## Structure
- Package `vga_timing_pkg`: default 640x480@60 constants (the eight timing values, sync polarities) and a total-width helper function used by the elaboration check.
- Sub-module `vga_axis_counter`, instantiated twice (horizontal and vertical). Per instance:
  - Parameters: SYNC, BP, ACTIVE, FP, CW.
  - Inputs: `step`.
  - Outputs: `cnt`, `wrap`, `in_sync`, `in_active`, `pos`.
- The top level holds the output registers, strobe logic and frame counter.

## Test plan
- Reset then `ce`=1 → `hsync` low for clocks 1–96 after release, `de` first high at h_cnt 144 with `x`=0, `x`=639 at h_cnt 783, `de` low at 784.
- Full frame at defaults → exactly 416800 clocks between `frame_start` pulses, 521 `line_start` pulses per frame, `vsync` low for 1600 clocks, 480 lines with `de`.
- `ce` high 1 clock in 4 → every level output holds for 4 clocks, `frame_start` width 1 clock, frame period 1667200 clocks.
- HS_POL=1, VS_POL=1, H_ACTIVE=16, V_ACTIVE=8, all porches/syncs=2 → `hsync` high for 2 pixels, H_TOTAL=22, `y` runs 0..7, the syncs idle at 0 during reset.
- `rst` pulsed at v_cnt=200 → all outputs at reset values asynchronously, and the next `ce` edge gives `frame_start` and `line_start`.
- With `VGA_TIMING_FRAME_CNT_EN` and FCW=2 → `frame_cnt` reads 0,1,2,3,0 across five successive completed frames. Without the macro → constant 0.
